// File: rtl/rc5_encrypt.sv
// rc5_encrypt -- iterative RC5-16 encryption core (16-bit words, 32-bit block).
//
// Takes the expanded subkey table from the key-expansion block once it is
// ready. Pre-whitening is applied when a block is accepted, then one full
// RC5 round is computed per cycle. The result is presented on a valid/ready
// handshake.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   keys_ready  subkey table valid (from key expansion)
//   subkeys     flattened table, S[k] = subkeys[k*16 +: 16], k = 0..T_MAX-1
//   num_rounds  requested round count, sampled at accept, clamped to MAX_ROUNDS
//   in_valid    plaintext offered
//   in_ready    core can accept a block
//   plaintext   block, [15:0] = A, [31:16] = B
//   out_valid   ciphertext valid
//   out_ready   consumer accepts ciphertext
//   ciphertext  result, [15:0] = A, [31:16] = B (registered)
//   busy        high while a block is in ROUND or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a block; in_ready follows keys_ready
// ROUND | one RC5 round per cycle, round index rnd_q = 1..r_lat_q
// DONE  | ciphertext held with out_valid until out_ready
module rc5_encrypt #(
   parameter int W_SIZE     = 16,
   parameter int T_MAX      = 34,
   parameter int MAX_ROUNDS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    keys_ready,
   input  logic [T_MAX*W_SIZE-1:0] subkeys,
   input  logic [4:0]              num_rounds,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*W_SIZE-1:0]     plaintext,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*W_SIZE-1:0]     ciphertext,
   output logic                    busy
);

   localparam int         SH_W  = $clog2(W_SIZE);
   localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   logic [W_SIZE-1:0]   a_q;
   logic [W_SIZE-1:0]   b_q;
   logic [4:0]          rnd_q;
   logic [4:0]          r_lat_q;

   logic [W_SIZE-1:0]   s_tab [T_MAX];
   logic [W_SIZE-1:0]   a_wht;
   logic [W_SIZE-1:0]   b_wht;
   logic [W_SIZE-1:0]   a_new;
   logic [W_SIZE-1:0]   b_new;
   logic [4:0]          r_clamp;
   logic                accept;

   function automatic logic [W_SIZE-1:0] rotl(input logic [W_SIZE-1:0] x,
                                              input logic [SH_W-1:0]   n);
      logic [2*W_SIZE-1:0] d;
      d = {x, x} << n;
      return d[2*W_SIZE-1:W_SIZE];
   endfunction

   always_comb begin
      for (int k = 0; k < T_MAX; k++) begin
         s_tab[k] = subkeys[k*W_SIZE +: W_SIZE];
      end
   end

   // Reset is folded in so in_ready stays low for the whole reset window,
   // even though state already reads IDLE.
   assign in_ready = rst && keys_ready && (state == IDLE);
   assign accept   = in_valid && in_ready;

   assign r_clamp = (num_rounds > MAX_R) ? MAX_R : num_rounds;

   assign a_wht = plaintext[W_SIZE-1:0] + s_tab[0];
   assign b_wht = plaintext[2*W_SIZE-1:W_SIZE] + s_tab[1];

   // rnd_q never exceeds MAX_ROUNDS (it is not advanced on the last round),
   // so the odd index tops out at 2*MAX_ROUNDS+1 = T_MAX-1.
   assign a_new = rotl(a_q ^ b_q, b_q[SH_W-1:0]) + s_tab[{rnd_q, 1'b0}];
   assign b_new = rotl(b_q ^ a_new, a_new[SH_W-1:0]) + s_tab[{rnd_q, 1'b1}];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         rnd_q      <= '0;
         r_lat_q    <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         ciphertext <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q     <= a_wht;
                  b_q     <= b_wht;
                  r_lat_q <= r_clamp;
                  rnd_q   <= 5'd1;
                  busy    <= 1'b1;
                  if (r_clamp == 5'd0) begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     ciphertext <= {b_wht, a_wht};
                  end else begin
                     state <= ROUND;
                  end
               end
            end
            ROUND: begin
               a_q <= a_new;
               b_q <= b_new;
               if (rnd_q == r_lat_q) begin
                  state      <= DONE;
                  out_valid  <= 1'b1;
                  ciphertext <= {b_new, a_new};
               end else begin
                  rnd_q <= rnd_q + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc5_encrypt.sv
module tb_rc5_encrypt;

   localparam int T_MAX = 34;

   logic              clk;
   logic              rst;
   logic              keys_ready;
   logic [T_MAX*16-1:0] subkeys;
   logic [4:0]        num_rounds;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       plaintext;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       ciphertext;
   logic              busy;

   logic [15:0] S [T_MAX];
   int n_checks;
   int n_errors;

   rc5_encrypt dut (
      .clk        (clk),
      .rst        (rst),
      .keys_ready (keys_ready),
      .subkeys    (subkeys),
      .num_rounds (num_rounds),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rol16(input int x, input int n);
      int v;
      v = x & 'hFFFF;
      return ((v << (n % 16)) | (v >> (16 - (n % 16)))) & 'hFFFF;
   endfunction

   // Software RC5-16 encryption straight from the algorithm definition.
   function automatic logic [31:0] rc5_model(input logic [31:0] pt, input int r);
      int rr, a, b;
      rr = (r > 16) ? 16 : r;
      a = (int'(pt[15:0]) + int'(S[0])) & 'hFFFF;
      b = (int'(pt[31:16]) + int'(S[1])) & 'hFFFF;
      for (int i = 1; i <= rr; i++) begin
         a = (rol16(a ^ b, b) + int'(S[2*i])) & 'hFFFF;
         b = (rol16(b ^ a, a) + int'(S[2*i+1])) & 'hFFFF;
      end
      return {b[15:0], a[15:0]};
   endfunction

   // RC5-16 key schedule for an all-zero key (one zero word of L).
   task automatic keyexp_zero();
      int a, b, ii, l0, tmp;
      S[0] = 16'hB7E1;
      for (int k = 1; k < T_MAX; k++) S[k] = S[k-1] + 16'h9E37;
      a = 0; b = 0; ii = 0; l0 = 0;
      for (int k = 0; k < 3*T_MAX; k++) begin
         tmp = rol16(int'(S[ii]) + a + b, 3);
         S[ii] = tmp[15:0];
         a = tmp;
         l0 = rol16(l0 + a + b, (a + b) & 15);
         b = l0;
         ii = (ii + 1) % T_MAX;
      end
   endtask

   task automatic load_keys();
      for (int k = 0; k < T_MAX; k++) subkeys[k*16 +: 16] = S[k];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One block: offer, accept, count edges to out_valid (accept edge = 1),
   // hold in DONE for 'hold' cycles with in_valid pulses, then release.
   task automatic run_block(input string tag, input logic [31:0] pt, input int r,
                            input int hold, input bit drop_keys);
      logic [31:0] exp_ct;
      int lat, exp_lat, wait_cnt;
      exp_ct  = rc5_model(pt, r);
      exp_lat = ((r > 16) ? 16 : r) + 1;
      keys_ready = 1'b1;
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
         tick();
         wait_cnt++;
      end
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      plaintext  = pt;
      num_rounds = 5'(r);
      in_valid   = 1'b1;
      out_ready  = 1'b0;
      tick();
      in_valid   = 1'b0;
      num_rounds = 5'($urandom);
      plaintext  = $urandom;
      if (drop_keys) keys_ready = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_ct"}, ciphertext, exp_ct);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         tick();
         chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         chk({tag, "_hold_ct"}, ciphertext, exp_ct);
         chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      keys_ready = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_release_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_retain_ct"}, ciphertext, exp_ct);
   endtask

   initial begin
      logic [31:0] pt;
      int r;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      keys_ready = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      num_rounds = 5'd0;
      plaintext = 32'd0;
      for (int k = 0; k < T_MAX; k++) S[k] = 16'd0;
      load_keys();

      tick();
      tick();
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_ct", ciphertext, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Zero keys, r=0
      run_block("t1", 32'h12345678, 0, 0, 1'b0);
      chk("t1_const", ciphertext, 32'h12345678);

      // Whitening only with carry wrap
      S[0] = 16'h0001; S[1] = 16'h0002;
      load_keys();
      run_block("t2", 32'h0000FFFF, 0, 0, 1'b0);
      chk("t2_const", ciphertext, 32'h00020000);

      // One round, zero keys
      S[0] = 16'h0000; S[1] = 16'h0000;
      load_keys();
      run_block("t3", 32'h12345678, 1, 0, 1'b0);
      chk("t3_const", ciphertext, 32'h6F0544C4);

      // Key-expansion table, r=12 and clamped r=31
      keyexp_zero();
      load_keys();
      run_block("t4_r12", 32'h00000000, 12, 0, 1'b0);
      run_block("t4_r31", 32'h00000000, 31, 0, 1'b1);
      run_block("t4_r16", 32'hDEADBEEF, 16, 0, 1'b0);

      // Backpressure for 10 cycles with in_valid pulses
      run_block("t5", 32'hCAFE1234, 5, 10, 1'b0);
      chk("t5_idle_in_ready", {31'd0, in_ready}, 32'd1);

      // keys_ready low blocks accept
      keys_ready = 1'b0;
      in_valid = 1'b1;
      plaintext = 32'h55AA55AA;
      num_rounds = 5'd3;
      for (int k = 0; k < 5; k++) tick();
      chk("t6_no_accept_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_no_accept_busy", {31'd0, busy}, 32'd0);
      in_valid = 1'b0;
      keys_ready = 1'b1;

      // Reset during round 4 of an r=8 block
      tick();
      plaintext = 32'h0BADF00D;
      num_rounds = 5'd8;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("t6_mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_ct", ciphertext, 32'd0);
      chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      run_block("t6_after", 32'h13579BDF, 1, 0, 1'b0);

      // Randomised blocks with random tables
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < T_MAX; k++) S[k] = 16'($urandom);
         load_keys();
         pt = $urandom;
         r = int'($urandom_range(0, 31));
         run_block("rand", pt, r, int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rc5_encrypt.md
Name: rc5_encrypt

Overview:
- Iterative RC5-16 encryption core (16-bit words, 32-bit block).
- Sits directly downstream of the key-expansion block and consumes its expanded subkey table once that block signals ready.
- Each accepted block runs pre-whitening, then one full RC5 round per cycle.
- The ciphertext is presented on a valid/ready output handshake.

Parameters:
- W_SIZE, 16, word width in bits; rotate amount uses the low log2(W_SIZE)=4 bits.
- T_MAX, 34, subkey table depth, 2*(max rounds+1).
- MAX_ROUNDS, 16, upper bound on rounds (T_MAX/2-1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- keys_ready  in  1  subkey table valid; driven by the key-expansion block's ready.
- subkeys  in  T_MAX x 16  expanded table S[0..T_MAX-1].
- num_rounds  in  5  requested round count r; sampled at accept.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  core can accept a block.
- plaintext  in  32  block; [15:0]=A, [31:16]=B.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- ciphertext  out  32  result; [15:0]=A, [31:16]=B.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; A, B, round counter and latched rounds = 0.
  - in_ready=0 while rst low; out_valid=0, busy=0, ciphertext=0.
- States: IDLE, ROUND, DONE.
- in_ready = (state==IDLE) && keys_ready. Accept = in_valid && in_ready.
- IDLE, on accept:
  - A <= plaintext[15:0] + S[0]; B <= plaintext[31:16] + S[1] (mod 2^16).
  - r_lat <= min(num_rounds, MAX_ROUNDS); round counter i <= 1.
  - Next state is ROUND if r_lat > 0, else DONE.
  - No accept means stay in IDLE.
- ROUND, one cycle per round, round index i in 1..r_lat:
  - A' = rotl(A ^ B, B[3:0]) + S[2i].
  - B' = rotl(B ^ A', A'[3:0]) + S[2i+1].
  - A' and B' are a single combinational chain within the cycle.
  - A <= A'; B <= B'; i <= i+1.
  - When i == r_lat, go to DONE.
- DONE:
  - out_valid=1; ciphertext = {B, A}, held stable.
  - On out_valid && out_ready, go to IDLE (in_ready may rise the next cycle).
  - Otherwise hold, including when out_ready stays low indefinitely.
- Latency: out_valid rises r_lat+1 rising edges after the accept edge (r=0 gives 1 cycle, r=16 gives 17 cycles).
  - Throughput: one block per r_lat+2 cycles minimum.
- Arithmetic:
  - All adds wrap modulo 2^16.
  - Rotation by 0 is identity.
  - Subkey index 2i+1 never exceeds 2*MAX_ROUNDS+1 = 33.
- Boundary conditions:
  - num_rounds > 16 is clamped to 16.
  - num_rounds changing after accept has no effect.
  - keys_ready low in IDLE blocks accept.
  - keys_ready dropping mid-operation is ignored; the core finishes. Holding subkeys stable from accept to DONE is a system requirement and is not checked here.
  - in_valid high while busy is ignored and the block is not consumed.
  - Async reset mid-ROUND or in DONE aborts immediately with no output. After release the core is in IDLE and a fresh accept restarts cleanly.
- ciphertext is registered (no combinational path from inputs).
  - It retains its last value in IDLE; only reset clears it.

Test Plan:
1. All subkeys 0, r=0, plaintext 0x12345678 -> out_valid 1 cycle after accept, ciphertext 0x12345678.
2. S[0]=0x0001, S[1]=0x0002, rest 0, r=0, plaintext 0x0000FFFF -> ciphertext 0x00020000.
3. All subkeys 0, r=1, plaintext 0x12345678 -> after 2 cycles ciphertext 0x6F0544C4 (A'=0x44C4, B'=0x6F05).
4. Subkeys from key-expansion block (all-zero key), r=12 vs r=31 -> r=31 clamped, behaves as r=16 with latency 17; r=12 latency 13; results match the software RC5-16 model.
5. Backpressure: out_ready held 0 for 10 cycles in DONE -> ciphertext and out_valid stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
6. keys_ready=0 with in_valid=1 -> no accept. Assert rst=0 mid-ROUND (r=8, round 4) -> out_valid, busy and ciphertext go to 0 asynchronously. After release, a new r=1 block produces the correct result.
